// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared types for the pipeline.
//   word_t            32-bit datapath word
//   fetch_state_t     fetch stage FSM encoding
//   PC_STRIDE_DEFAULT default sequential PC increment in bytes
//   align_word()      clears the byte-offset bits of an address
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam int unsigned PC_STRIDE_DEFAULT = 4;

  function automatic word_t align_word(input word_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: one-entry buffer for an instruction (and its next address)
// that returned from memory while the pipeline was stalled.
// Ports:
//   CLK, nRST   clock, synchronous active-low reset (clears the entry)
//   load_i      capture instr_i/npc_i
//   clear_i     drop the entry (load_i wins if both are set)
//   instr_i/o   buffered instruction
//   npc_i/o     buffered next address
module fetch_hold_buf
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  load_i,
  input  logic  clear_i,
  input  word_t instr_i,
  input  word_t npc_i,
  output word_t instr_o,
  output word_t npc_o
);

  word_t instr_q, instr_d;
  word_t npc_q, npc_d;

  always_comb begin
    instr_d = instr_q;
    npc_d   = npc_q;
    if (load_i) begin
      instr_d = instr_i;
      npc_d   = npc_i;
    end else if (clear_i) begin
      instr_d = '0;
      npc_d   = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      instr_q <= '0;
      npc_q   <= '0;
    end else begin
      instr_q <= instr_d;
      npc_q   <= npc_d;
    end
  end

  assign instr_o = instr_q;
  assign npc_o   = npc_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage. Owns the PC, issues instruction reads
// and feeds the IF/ID register. A fetch that completes under stall is parked
// in a one-entry hold buffer instead of being refetched.
// Ports:
//   CLK, nRST                  clock, synchronous active-low reset
//   ihit, imemload             instruction memory response
//   stall, redirect(_addr)     hazard hold, branch/jump target
//   halt                       halt retired in WB (sticky until reset)
//   imemREN, imemaddr          instruction read request
//   ifid_wen/flush/next_address/instruction   IF/ID register inputs
// Build option FETCH_PERF_EN adds perf_fetched and perf_stall counters.
//
// state  | meaning
// FETCH  | request at pc, deliver on ihit
// HOLD   | fetched instr parked in hold buffer, waiting for stall to drop
// HALTED | halt seen, pc frozen, IF/ID flushed until reset
module fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t       PC_INIT   = 32'h0000_0000,
  parameter int unsigned PC_STRIDE = PC_STRIDE_DEFAULT
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  ihit,
  input  word_t imemload,
  input  logic  stall,
  input  logic  redirect,
  input  word_t redirect_addr,
  input  logic  halt,
  output logic  imemREN,
  output word_t imemaddr,
  output logic  ifid_wen,
  output logic  ifid_flush,
  output word_t ifid_next_address,
  output word_t ifid_instruction
`ifdef FETCH_PERF_EN
  ,
  output word_t perf_fetched,
  output word_t perf_stall
`endif
);

  fetch_state_t state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        pc_inc;
  word_t        hold_instr, hold_npc;
  logic         hold_load, hold_clear;

  assign pc_inc = pc_q + word_t'(PC_STRIDE);

  fetch_hold_buf u_hold_buf (
    .CLK     (CLK),
    .nRST    (nRST),
    .load_i  (hold_load),
    .clear_i (hold_clear),
    .instr_i (imemload),
    .npc_i   (pc_inc),
    .instr_o (hold_instr),
    .npc_o   (hold_npc)
  );

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    hold_load  = 1'b0;
    hold_clear = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (halt) begin
          state_d = HALTED;
        end else if (redirect) begin
          pc_d = align_word(redirect_addr);
        end else if (ihit) begin
          // pc advances even under stall; the fetched word lives in the buffer
          pc_d = pc_inc;
          if (stall) begin
            hold_load = 1'b1;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        if (halt) begin
          state_d = HALTED;
        end else if (redirect) begin
          hold_clear = 1'b1;
          pc_d       = align_word(redirect_addr);
          state_d    = FETCH;
        end else if (!stall) begin
          state_d = FETCH;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_comb begin
    imemREN           = 1'b0;
    imemaddr          = pc_q;
    ifid_wen          = 1'b0;
    ifid_flush        = 1'b0;
    ifid_next_address = '0;
    ifid_instruction  = '0;
    if (!nRST) begin
      ifid_flush = 1'b1;
    end else begin
      unique case (state_q)
        FETCH: begin
          imemREN = 1'b1;
          if (halt || redirect) begin
            ifid_flush = 1'b1;
          end else if (!stall) begin
            if (ihit) begin
              ifid_wen          = 1'b1;
              ifid_instruction  = imemload;
              ifid_next_address = pc_inc;
            end else begin
              ifid_flush = 1'b1;
            end
          end
        end
        HOLD: begin
          if (halt || redirect) begin
            ifid_flush = 1'b1;
          end else if (!stall) begin
            ifid_wen          = 1'b1;
            ifid_instruction  = hold_instr;
            ifid_next_address = hold_npc;
          end
        end
        HALTED: begin
          ifid_flush = 1'b1;
        end
        default: begin
          ifid_flush = 1'b1;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  word_t perf_fetched_q, perf_stall_q;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else if (state_q != HALTED) begin
      if (ifid_wen) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (stall)    perf_stall_q   <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import cpu_types_pkg::*;

  logic  CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic  nRST, ihit, stall, redirect, halt;
  word_t imemload, redirect_addr;

  logic  imemREN, ifid_wen, ifid_flush;
  word_t imemaddr, ifid_next_address, ifid_instruction;
  logic  w_imemREN, w_ifid_wen, w_ifid_flush;
  word_t w_imemaddr, w_ifid_next_address, w_ifid_instruction;
`ifdef FETCH_PERF_EN
  word_t perf_fetched, perf_stall, w_perf_fetched, w_perf_stall;
`endif

  fetch_stage dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .stall(stall),
    .redirect(redirect), .redirect_addr(redirect_addr), .halt(halt),
    .imemREN(imemREN), .imemaddr(imemaddr), .ifid_wen(ifid_wen),
    .ifid_flush(ifid_flush), .ifid_next_address(ifid_next_address),
    .ifid_instruction(ifid_instruction)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_stall(perf_stall)
`endif
  );

  fetch_stage #(.PC_INIT(32'hFFFF_FFFC)) dut_w (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload), .stall(stall),
    .redirect(redirect), .redirect_addr(redirect_addr), .halt(halt),
    .imemREN(w_imemREN), .imemaddr(w_imemaddr), .ifid_wen(w_ifid_wen),
    .ifid_flush(w_ifid_flush), .ifid_next_address(w_ifid_next_address),
    .ifid_instruction(w_ifid_instruction)
`ifdef FETCH_PERF_EN
    , .perf_fetched(w_perf_fetched), .perf_stall(w_perf_stall)
`endif
  );

  typedef struct {
    logic  nrst, ihit;  word_t load;
    logic  stall, redir; word_t raddr; logic halt;
    logic  ren, care_addr; word_t addr;
    logic  wen, flush;  word_t naddr, instr;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic vec_t mk(logic nrst, logic ih, word_t ld, logic st, logic rd,
                              word_t ra, logic hl, logic ren, logic ca, word_t ad,
                              logic wen, logic fl, word_t na, word_t ins);
    vec_t v;
    v.nrst = nrst; v.ihit = ih; v.load = ld; v.stall = st; v.redir = rd;
    v.raddr = ra; v.halt = hl; v.ren = ren; v.care_addr = ca; v.addr = ad;
    v.wen = wen; v.flush = fl; v.naddr = na; v.instr = ins;
    return v;
  endfunction

  task automatic chk(input string name, input word_t act, input word_t exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    vec_t e;
    @(posedge CLK);
    #1;
    nRST = v.nrst; ihit = v.ihit; imemload = v.load; stall = v.stall;
    redirect = v.redir; redirect_addr = v.raddr; halt = v.halt;
    sb.push_back(v);
    #3;
    e = sb.pop_front();
    vectors++;
    chk("imemREN", word_t'(imemREN), word_t'(e.ren));
    if (e.care_addr) chk("imemaddr", imemaddr, e.addr);
    chk("ifid_wen", word_t'(ifid_wen), word_t'(e.wen));
    chk("ifid_flush", word_t'(ifid_flush), word_t'(e.flush));
    chk("ifid_next_address", ifid_next_address, e.naddr);
    chk("ifid_instruction", ifid_instruction, e.instr);
    chk("wen_and_flush", word_t'(ifid_wen & ifid_flush), 32'd0);
  endtask

  initial begin
    nRST = 1'b0; ihit = 1'b0; stall = 1'b0; redirect = 1'b0; halt = 1'b0;
    imemload = '0; redirect_addr = '0;

    //            nrst ih load          st rd raddr        hl ren ca addr          wen fl naddr         instr
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,       0, 0, 0, 32'h0,        0, 1, 32'h0,        32'h0));
    tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,       0, 0, 1, 32'h0,        0, 1, 32'h0,        32'h0));
    tbl.push_back(mk(1, 1, 32'hA000_0000,0, 0, 32'h0,       0, 1, 1, 32'h0,        1, 0, 32'h4,        32'hA000_0000));
    tbl.push_back(mk(1, 1, 32'hA000_0001,0, 0, 32'h0,       0, 1, 1, 32'h4,        1, 0, 32'h8,        32'hA000_0001));
    tbl.push_back(mk(1, 1, 32'hA000_0002,1, 0, 32'h0,       0, 1, 1, 32'h8,        0, 0, 32'h0,        32'h0));
    tbl.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,       0, 0, 1, 32'hC,        0, 0, 32'h0,        32'h0));
    tbl.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,       0, 0, 1, 32'hC,        0, 0, 32'h0,        32'h0));
    tbl.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,       0, 0, 1, 32'hC,        1, 0, 32'hC,        32'hA000_0002));
    tbl.push_back(mk(1, 1, 32'hA000_0003,0, 0, 32'h0,       0, 1, 1, 32'hC,        1, 0, 32'h10,       32'hA000_0003));
    tbl.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,       0, 1, 1, 32'h10,       0, 1, 32'h0,        32'h0));
    tbl.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,       0, 1, 1, 32'h10,       0, 0, 32'h0,        32'h0));
    tbl.push_back(mk(1, 1, 32'hDEAD_BEEF,0, 1, 32'h43,      0, 1, 1, 32'h10,       0, 1, 32'h0,        32'h0));
    tbl.push_back(mk(1, 1, 32'hB000_0000,1, 0, 32'h0,       0, 1, 1, 32'h40,       0, 0, 32'h0,        32'h0));
    tbl.push_back(mk(1, 0, 32'h0,        1, 1, 32'h43,      0, 0, 1, 32'h44,       0, 1, 32'h0,        32'h0));
    tbl.push_back(mk(1, 1, 32'hB000_0001,0, 0, 32'h0,       0, 1, 1, 32'h40,       1, 0, 32'h44,       32'hB000_0001));
    tbl.push_back(mk(1, 1, 32'hB000_0002,1, 0, 32'h0,       0, 1, 1, 32'h44,       0, 0, 32'h0,        32'h0));
    tbl.push_back(mk(0, 1, 32'hB000_0003,1, 0, 32'h0,       0, 0, 0, 32'h0,        0, 1, 32'h0,        32'h0));
    tbl.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,       0, 1, 1, 32'h0,        0, 1, 32'h0,        32'h0));
    tbl.push_back(mk(1, 1, 32'hC000_0000,0, 0, 32'h0,       0, 1, 1, 32'h0,        1, 0, 32'h4,        32'hC000_0000));
    tbl.push_back(mk(1, 1, 32'hD000_0000,0, 1, 32'h80,      1, 1, 1, 32'h4,        0, 1, 32'h0,        32'h0));
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk(1, k[0], 32'hE000_0000 + k, k[1], 1, 32'h100 + 32'(k * 16),
                       0, 0, 1, 32'h4, 0, 1, 32'h0, 32'h0));

    foreach (tbl[i]) apply(tbl[i]);

    // PC wraparound on the PC_INIT=FFFF_FFFC instance (both DUTs see the same inputs)
    apply(mk(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 1, 32'h0, 32'h0));
    apply(mk(1, 1, 32'hF000_0000, 0, 0, 32'h0, 0, 1, 1, 32'h0, 1, 0, 32'h4, 32'hF000_0000));
    vectors++;
    chk("wrap_imemaddr_before", w_imemaddr, 32'hFFFF_FFFC);
    chk("wrap_next_address", w_ifid_next_address, 32'h0);
    chk("wrap_wen", word_t'(w_ifid_wen), 32'd1);
    apply(mk(1, 0, 32'h0, 0, 0, 32'h0, 0, 1, 1, 32'h4, 0, 1, 32'h0, 32'h0));
    vectors++;
    chk("wrap_imemaddr_after", w_imemaddr, 32'h0);

`ifdef FETCH_PERF_EN
    apply(mk(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 32'h0, 0, 1, 32'h0, 32'h0));
    for (int k = 0; k < 5; k++)
      apply(mk(1, 1, 32'h5000_0000 + k, 0, 0, 32'h0, 0, 1, 1, 32'(k * 4), 1, 0,
               32'(k * 4 + 4), 32'h5000_0000 + k));
    for (int k = 0; k < 3; k++)
      apply(mk(1, 0, 32'h0, 1, 0, 32'h0, 0, 1, 1, 32'h14, 0, 0, 32'h0, 32'h0));
    apply(mk(1, 0, 32'h0, 0, 0, 32'h0, 1, 1, 1, 32'h14, 0, 1, 32'h0, 32'h0));
    for (int k = 0; k < 4; k++)
      apply(mk(1, 1, 32'h0, 1, 0, 32'h0, 0, 0, 1, 32'h14, 0, 1, 32'h0, 32'h0));
    vectors++;
    chk("perf_fetched", perf_fetched, 32'd5);
    chk("perf_stall", perf_stall, 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
